// File: rtl/parking_fee_unit.sv
// -----------------------------------------------------------------------------
// parking_fee_unit
//
// Billing stage behind the parking controller. It watches the 4-bit occupancy
// vector F for spot releases (1->0) and captures the elapsed time of each
// released spot. It converts that time to started billing units with a serial
// restoring divider, then computes a saturated fee. The fee is offered on a
// valid/ready handshake, and accepted fees are added to a saturating revenue
// total.
//
// Ports
//   CLK                      clock
//   RST                      synchronous active-low reset
//   F[3:0]                   occupancy flags, bit N = spot N occupied
//   spot0_time..spot3_time   elapsed cycles per spot (TIME_W bits)
//   fee_ready                consumer accepts the current fee record
//   fee_valid                fee record available
//   fee_spot[1:0]            spot index of the record
//   fee_units[TIME_W-1:0]    billed units (ceiling of time / UNIT_CYCLES)
//   fee_amount[FEE_W-1:0]    fee, clamped to MAX_FEE
//   revenue[31:0]            accumulated accepted fees, saturating
//   busy                     engine not idle, or a release is still pending
//   drop_err                 sticky: a release arrived while that spot was
//                            already pending, and the event was lost
//
// Build option
//   FEE_GRACE_EN  when defined, a stay shorter than GRACE_CYCLES is emitted
//                 with zero units and a zero fee.
// -----------------------------------------------------------------------------
module parking_fee_unit #(
  parameter int unsigned TIME_W       = 64,
  parameter int unsigned FEE_W        = 16,
  parameter int unsigned UNIT_CYCLES  = 100,
  parameter int unsigned BASE_FEE     = 5,
  parameter int unsigned RATE         = 2,
  parameter int unsigned MAX_FEE      = 1000
`ifdef FEE_GRACE_EN
  , parameter int unsigned GRACE_CYCLES = 50
`else
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [3:0]        F,
  input  logic [TIME_W-1:0] spot0_time,
  input  logic [TIME_W-1:0] spot1_time,
  input  logic [TIME_W-1:0] spot2_time,
  input  logic [TIME_W-1:0] spot3_time,
  input  logic              fee_ready,
  output logic              fee_valid,
  output logic [1:0]        fee_spot,
  output logic [TIME_W-1:0] fee_units,
  output logic [FEE_W-1:0]  fee_amount,
  output logic [31:0]       revenue,
  output logic              busy,
  output logic              drop_err
);

  typedef enum logic [1:0] {IDLE, DIV, CALC, OUT} state_t;

  localparam int unsigned CNT_W = $clog2(TIME_W + 1);
  // The fee is formed wide enough that RATE * units can never wrap before the clamp.
  localparam int unsigned FULL_W = TIME_W + 34;
  localparam logic [TIME_W:0]   DIVISOR   = (TIME_W + 1)'(UNIT_CYCLES);
  localparam logic [FEE_W-1:0]  MAX_FEE_V = FEE_W'(MAX_FEE);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(TIME_W - 1);

  state_t              state_q, state_d;
  logic [3:0]          f_q;
  logic [TIME_W-1:0]   t_q   [4];
  logic [TIME_W-1:0]   cap_q [4];
  logic [3:0]          pending_q;
  logic [3:0]          rel;
  logic [3:0]          clr;
  logic [1:0]          sel;
  logic [1:0]          spot_q;
  logic [TIME_W-1:0]   quo_q;
  logic [TIME_W:0]     rem_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                load_div, div_step, calc_en, accept;
  logic [TIME_W:0]     trial, rem_d;
  logic                q_bit;
  logic [TIME_W-1:0]   units_c;
  logic [FULL_W-1:0]   fee_full;
  logic [32:0]         rev_sum;
  logic                grace_hit;
`ifdef FEE_GRACE_EN
  logic                grace_q;
`else
`endif

  // Release = occupied on the previous edge, free now.
  assign rel = f_q & ~F;

  // Lowest-index pending spot wins arbitration.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i]) sel = 2'(i);
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (|pending_q)              state_d = DIV;
      DIV:  if (cnt_q == LAST_STEP)      state_d = CALC;
      CALC:                              state_d = OUT;
      OUT:  if (fee_ready)               state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs / strobes ----------------
  always_comb begin
    load_div = 1'b0;
    div_step = 1'b0;
    calc_en  = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: load_div = |pending_q;
      DIV:  div_step = 1'b1;
      CALC: calc_en  = 1'b1;
      OUT:  accept   = fee_ready;   // fee_valid is high exactly while in OUT
      default: ;
    endcase
    busy = (state_q != IDLE) | (|pending_q);
  end

  assign clr = load_div ? (4'b0001 << sel) : 4'b0000;

  // One restoring-division step: shift in the next dividend bit and subtract if it fits.
  assign trial = {rem_q[TIME_W-1:0], quo_q[TIME_W-1]};
  assign q_bit = (trial >= DIVISOR);
  assign rem_d = q_bit ? (trial - DIVISOR) : trial;

  // Ceiling: a non-zero remainder means a started unit.
  assign units_c  = quo_q + TIME_W'(rem_q != '0);
  assign fee_full = FULL_W'(BASE_FEE) + FULL_W'(RATE) * FULL_W'(units_c);
  assign rev_sum  = {1'b0, revenue} + 33'(fee_amount);

`ifdef FEE_GRACE_EN
  assign grace_hit = grace_q;
`else
  assign grace_hit = 1'b0;
`endif

  // ---------------- capture and pending bookkeeping ----------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      f_q       <= '0;
      pending_q <= '0;
      drop_err  <= 1'b0;
      // NOTE: the small time register files are reset explicitly because their contents are observable state.
      for (int i = 0; i < 4; i++) begin
        t_q[i]   <= '0;
        cap_q[i] <= '0;
      end
    end else begin
      f_q    <= F;
      t_q[0] <= spot0_time;
      t_q[1] <= spot1_time;
      t_q[2] <= spot2_time;
      t_q[3] <= spot3_time;
      for (int i = 0; i < 4; i++) begin
        if (rel[i]) begin
          // A release that lands on the edge the engine takes this spot is not lost.
          if (pending_q[i] && !clr[i]) begin
            drop_err <= 1'b1;
          end else begin
            cap_q[i] <= t_q[i];
          end
          pending_q[i] <= 1'b1;
        end else if (clr[i]) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------- divider, fee and handshake datapath ----------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      spot_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      fee_valid  <= 1'b0;
      fee_spot   <= '0;
      fee_units  <= '0;
      fee_amount <= '0;
      revenue    <= '0;
`ifdef FEE_GRACE_EN
      grace_q    <= 1'b0;
`else
`endif
    end else begin
      if (load_div) begin
        spot_q <= sel;
        quo_q  <= cap_q[sel];
        rem_q  <= '0;
        cnt_q  <= '0;
`ifdef FEE_GRACE_EN
        grace_q <= (cap_q[sel] < TIME_W'(GRACE_CYCLES));
`else
`endif
      end
      if (div_step) begin
        quo_q <= {quo_q[TIME_W-2:0], q_bit};
        rem_q <= rem_d;
        cnt_q <= cnt_q + 1'b1;
      end
      if (calc_en) begin
        fee_valid <= 1'b1;
        fee_spot  <= spot_q;
        if (grace_hit) begin
          fee_units  <= '0;
          fee_amount <= '0;
        end else begin
          fee_units  <= units_c;
          fee_amount <= (fee_full > FULL_W'(MAX_FEE)) ? MAX_FEE_V : fee_full[FEE_W-1:0];
        end
      end
      if (accept) begin
        fee_valid <= 1'b0;
        revenue   <= rev_sum[32] ? 32'hFFFF_FFFF : rev_sum[31:0];
      end
    end
  end

endmodule
